axi_rw_arbiter: RTL
===================

Name: axi_rw_arbiter

Overview:
- Shares the core's single AXI4 master port between two requesters: instruction fetch (IF, read-only) and data memory (MEM, read/write).
- Converts each accepted simple request into one single-beat AXI4 transaction and returns a one-cycle response pulse to the owner.
- Sits between the fetch/LSU stages and the AXI pins of the CPU top.
- Only one AXI transaction is outstanding at any time.

Parameters:
ADDR_W, 64, AXI address width
DATA_W, 64, AXI data width (strobe width DATA_W/8)
ID_W, 4, AXI ID width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req_valid  in  1  IF read request
if_req_ready  out  1  IF request accepted (one-cycle pulse)
if_req_addr  in  ADDR_W  IF read address
if_req_size  in  3  IF AXI size code
if_resp_valid  out  1  IF response pulse
if_resp_rdata  out  DATA_W  IF read data
if_resp_err  out  1  IF response error (resp != OKAY)
mem_req_valid  in  1  MEM request
mem_req_ready  out  1  MEM request accepted (one-cycle pulse)
mem_req_we  in  1  1 = write, 0 = read
mem_req_addr  in  ADDR_W  MEM address
mem_req_size  in  3  MEM AXI size code
mem_req_wdata  in  DATA_W  MEM write data
mem_req_wstrb  in  DATA_W/8  MEM write strobes
mem_resp_valid  out  1  MEM response pulse
mem_resp_rdata  out  DATA_W  MEM read data (0 for writes)
mem_resp_err  out  1  MEM response error
axi_aw_valid_o/ready_i  out/in  1  AW handshake
axi_aw_addr_o  out  ADDR_W  AW address
axi_aw_id_o  out  ID_W  AW ID
axi_aw_len_o  out  8  AW length
axi_aw_size_o  out  3  AW size
axi_aw_burst_o  out  2  AW burst
axi_w_valid_o/ready_i  out/in  1  W handshake
axi_w_data_o  out  DATA_W  write data
axi_w_strb_o  out  DATA_W/8  write strobes
axi_w_last_o  out  1  last beat
axi_b_valid_i/ready_o  in/out  1  B handshake
axi_b_resp_i  in  2  write response
axi_ar_valid_o/ready_i  out/in  1  AR handshake
axi_ar_addr_o  out  ADDR_W  AR address
axi_ar_id_o  out  ID_W  AR ID
axi_ar_len_o  out  8  AR length
axi_ar_size_o  out  3  AR size
axi_ar_burst_o  out  2  AR burst
axi_r_valid_i/ready_o  in/out  1  R handshake
axi_r_data_i  in  DATA_W  read data
axi_r_resp_i  in  2  read response
axi_r_last_i  in  1  last beat

Behaviour:
- Reset (async assert, sync deassert): state IDLE, last_grant=MEM, all valid/ready/resp outputs 0, latched request fields 0.
- Reset mid-transaction abandons the transaction; no response is issued.
- Constant outputs: len=0, burst=2'b01 (INCR), w_last=1. Transaction ID: IF=0, MEM=1.
- States: IDLE, AR, R, WR, B.
- IDLE:
  - Exactly one requester valid -> grant it.
  - Both valid -> grant the one not in last_grant (round-robin), then update last_grant.
  - Grant cycle: that requester's req_ready=1 for one cycle; addr/size/we/wdata/wstrb and owner are latched.
  - Next state: WR if MEM with we=1, else AR.
- AR: ar_valid=1 with the latched fields. On ar_ready -> R.
- R:
  - r_ready=1. On r_valid, a one-cycle resp_valid pulse goes to the owner, with rdata=r_data and err=(r_resp!=0); -> IDLE.
  - r_last is ignored (single beat).
- WR:
  - aw_valid and w_valid both assert on entry.
  - Each deasserts independently the cycle after its own handshake.
  - When both handshakes are done (same or different cycles) -> B.
- B: b_ready=1. On b_valid, mem_resp_valid pulses with rdata=0 and err=(b_resp!=0); -> IDLE.
- Latency:
  - Grant -> ar_valid/aw_valid takes 1 cycle.
  - Response pulse is registered, 1 cycle after the R/B handshake.
  - Next grant is possible in the same cycle as the response pulse, since the state is IDLE then.
- The response pulse has no backpressure; the requester must accept it.
- AXI valid signals never drop before their ready; address and data stay stable while valid is high.
- A request that is valid while busy waits; req_ready stays 0 until granted.

Test Plan:
- IF read alone, addr=0x8000_0000, size=3, ar_ready after 2 cycles, r_data=0x1122334455667788, r_resp=0 -> ar_id=0, len=0, burst=1, if_resp_valid one cycle with that data, err=0.
- MEM write addr=0x8000_1000, wdata=0xDEAD, wstrb=0xFF; w_ready 3 cycles before aw_ready -> w_valid drops after its handshake, aw_valid held; b_resp=0 -> mem_resp_valid, err=0, rdata=0.
- IF and MEM valid together from reset, repeated back-to-back -> grants alternate IF, MEM, IF (last_grant=MEM at reset); each req_ready is a single pulse.
- MEM read with r_resp=2'b10 -> mem_resp_err=1, ar_id=1.
- Stall: ar_ready held 0 for 10 cycles with changing if_req inputs -> ar_valid and ar_addr stay stable, no second grant.
- rst_n asserted while in R -> all outputs 0 immediately; no resp_valid after release; next request handled normally.

Source files
------------

// File: rtl/axi_rw_arbiter_if.sv
// Bundle of the signals between the IF/MEM requesters, the arbiter and the
// AXI4 master pins.
//   master : arbiter side (takes requests, drives AXI requests and responses)
//   slave  : environment side (requesters plus AXI slave)
// Request side : if_req_* / mem_req_* in, *_req_ready and *_resp_* out.
// AXI side     : AW/W/AR out, B/R in, single-beat INCR transactions only.
interface axi_rw_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
);
    localparam int STRB_W = DATA_W / 8;

    logic              if_req_valid;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_req_addr;
    logic [2:0]        if_req_size;
    logic              if_resp_valid;
    logic [DATA_W-1:0] if_resp_rdata;
    logic              if_resp_err;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [2:0]        mem_req_size;
    logic [DATA_W-1:0] mem_req_wdata;
    logic [STRB_W-1:0] mem_req_wstrb;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_rdata;
    logic              mem_resp_err;

    logic              axi_aw_valid_o;
    logic              axi_aw_ready_i;
    logic [ADDR_W-1:0] axi_aw_addr_o;
    logic [ID_W-1:0]   axi_aw_id_o;
    logic [7:0]        axi_aw_len_o;
    logic [2:0]        axi_aw_size_o;
    logic [1:0]        axi_aw_burst_o;
    logic              axi_w_valid_o;
    logic              axi_w_ready_i;
    logic [DATA_W-1:0] axi_w_data_o;
    logic [STRB_W-1:0] axi_w_strb_o;
    logic              axi_w_last_o;
    logic              axi_b_valid_i;
    logic              axi_b_ready_o;
    logic [1:0]        axi_b_resp_i;
    logic              axi_ar_valid_o;
    logic              axi_ar_ready_i;
    logic [ADDR_W-1:0] axi_ar_addr_o;
    logic [ID_W-1:0]   axi_ar_id_o;
    logic [7:0]        axi_ar_len_o;
    logic [2:0]        axi_ar_size_o;
    logic [1:0]        axi_ar_burst_o;
    logic              axi_r_valid_i;
    logic              axi_r_ready_o;
    logic [DATA_W-1:0] axi_r_data_i;
    logic [1:0]        axi_r_resp_i;
    logic              axi_r_last_i;

    modport master (
        input  if_req_valid, if_req_addr, if_req_size,
        output if_req_ready, if_resp_valid, if_resp_rdata, if_resp_err,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_size,
               mem_req_wdata, mem_req_wstrb,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err,
        output axi_aw_valid_o, axi_aw_addr_o, axi_aw_id_o, axi_aw_len_o,
               axi_aw_size_o, axi_aw_burst_o,
        input  axi_aw_ready_i,
        output axi_w_valid_o, axi_w_data_o, axi_w_strb_o, axi_w_last_o,
        input  axi_w_ready_i,
        input  axi_b_valid_i, axi_b_resp_i,
        output axi_b_ready_o,
        output axi_ar_valid_o, axi_ar_addr_o, axi_ar_id_o, axi_ar_len_o,
               axi_ar_size_o, axi_ar_burst_o,
        input  axi_ar_ready_i,
        input  axi_r_valid_i, axi_r_data_i, axi_r_resp_i, axi_r_last_i,
        output axi_r_ready_o
    );

    modport slave (
        output if_req_valid, if_req_addr, if_req_size,
        input  if_req_ready, if_resp_valid, if_resp_rdata, if_resp_err,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_size,
               mem_req_wdata, mem_req_wstrb,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err,
        input  axi_aw_valid_o, axi_aw_addr_o, axi_aw_id_o, axi_aw_len_o,
               axi_aw_size_o, axi_aw_burst_o,
        output axi_aw_ready_i,
        input  axi_w_valid_o, axi_w_data_o, axi_w_strb_o, axi_w_last_o,
        output axi_w_ready_i,
        output axi_b_valid_i, axi_b_resp_i,
        input  axi_b_ready_o,
        input  axi_ar_valid_o, axi_ar_addr_o, axi_ar_id_o, axi_ar_len_o,
               axi_ar_size_o, axi_ar_burst_o,
        output axi_ar_ready_i,
        output axi_r_valid_i, axi_r_data_i, axi_r_resp_i, axi_r_last_i,
        input  axi_r_ready_o
    );
endinterface

// File: rtl/axi_rw_arbiter.sv
// Shares one AXI4 master port between instruction fetch (read-only) and the
// data-memory port (read/write). Each accepted request becomes one single-beat
// AXI transaction; the owner gets a registered one-cycle response pulse.
// At most one transaction is outstanding.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : request/response and AXI signals (axi_rw_arbiter_if.master)
module axi_rw_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    axi_rw_arbiter_if.master      bus
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_WR, S_B} state_t;

    state_t            r_state, w_state_nxt;
    logic              r_last_mem;   // last grant went to MEM
    logic              r_owner_mem;  // current transaction belongs to MEM
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_size;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;
    logic              r_aw_done, r_w_done;
    logic              r_if_resp_valid, r_mem_resp_valid, r_resp_err;
    logic [DATA_W-1:0] r_resp_rdata;

    logic w_idle, w_grant_if, w_grant_mem;
    logic w_ar_hs, w_aw_hs, w_w_hs, w_r_hs, w_b_hs;

    // rst_n is folded in so req_ready stays low while reset is held even if
    // a requester is already asserting valid.
    assign w_idle      = (r_state == S_IDLE) && rst_n;
    assign w_grant_if  = w_idle && bus.if_req_valid  && (!bus.mem_req_valid || r_last_mem);
    assign w_grant_mem = w_idle && bus.mem_req_valid && (!bus.if_req_valid  || !r_last_mem);

    assign w_ar_hs = (r_state == S_AR) && bus.axi_ar_ready_i;
    assign w_aw_hs = (r_state == S_WR) && !r_aw_done && bus.axi_aw_ready_i;
    assign w_w_hs  = (r_state == S_WR) && !r_w_done  && bus.axi_w_ready_i;
    assign w_r_hs  = (r_state == S_R)  && bus.axi_r_valid_i;
    assign w_b_hs  = (r_state == S_B)  && bus.axi_b_valid_i;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_mem)     w_state_nxt = bus.mem_req_we ? S_WR : S_AR;
                else if (w_grant_if) w_state_nxt = S_AR;
            end
            S_AR:   if (w_ar_hs) w_state_nxt = S_R;
            S_R:    if (w_r_hs)  w_state_nxt = S_IDLE;
            // AW and W may complete in either order or together
            S_WR:   if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_state_nxt = S_B;
            S_B:    if (w_b_hs)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request latch, handshake bookkeeping and registered responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_mem       <= 1'b1;
            r_owner_mem      <= 1'b0;
            r_addr           <= '0;
            r_size           <= '0;
            r_wdata          <= '0;
            r_wstrb          <= '0;
            r_aw_done        <= 1'b0;
            r_w_done         <= 1'b0;
            r_if_resp_valid  <= 1'b0;
            r_mem_resp_valid <= 1'b0;
            r_resp_err       <= 1'b0;
            r_resp_rdata     <= '0;
        end else begin
            r_if_resp_valid  <= 1'b0;
            r_mem_resp_valid <= 1'b0;
            if (w_grant_if || w_grant_mem) begin
                r_last_mem  <= w_grant_mem;
                r_owner_mem <= w_grant_mem;
                r_aw_done   <= 1'b0;
                r_w_done    <= 1'b0;
                if (w_grant_mem) begin
                    r_addr  <= bus.mem_req_addr;
                    r_size  <= bus.mem_req_size;
                    r_wdata <= bus.mem_req_wdata;
                    r_wstrb <= bus.mem_req_wstrb;
                end else begin
                    r_addr  <= bus.if_req_addr;
                    r_size  <= bus.if_req_size;
                    r_wdata <= '0;
                    r_wstrb <= '0;
                end
            end
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
            if (w_r_hs) begin
                r_if_resp_valid  <= !r_owner_mem;
                r_mem_resp_valid <= r_owner_mem;
                r_resp_rdata     <= bus.axi_r_data_i;
                r_resp_err       <= (bus.axi_r_resp_i != 2'b00);
            end
            if (w_b_hs) begin
                r_mem_resp_valid <= 1'b1;
                r_resp_rdata     <= '0;
                r_resp_err       <= (bus.axi_b_resp_i != 2'b00);
            end
        end
    end

    // Outputs: AXI valids/readies decode straight from the state so they are
    // glitch-free and drop asynchronously with reset.
    always_comb begin
        bus.if_req_ready   = w_grant_if;
        bus.mem_req_ready  = w_grant_mem;
        bus.if_resp_valid  = r_if_resp_valid;
        bus.if_resp_rdata  = r_resp_rdata;
        bus.if_resp_err    = r_resp_err;
        bus.mem_resp_valid = r_mem_resp_valid;
        bus.mem_resp_rdata = r_resp_rdata;
        bus.mem_resp_err   = r_resp_err;

        bus.axi_ar_valid_o = (r_state == S_AR);
        bus.axi_ar_addr_o  = r_addr;
        bus.axi_ar_id_o    = {{(ID_W-1){1'b0}}, r_owner_mem};
        bus.axi_ar_len_o   = 8'd0;
        bus.axi_ar_size_o  = r_size;
        bus.axi_ar_burst_o = 2'b01;
        bus.axi_r_ready_o  = (r_state == S_R);

        bus.axi_aw_valid_o = (r_state == S_WR) && !r_aw_done;
        bus.axi_aw_addr_o  = r_addr;
        bus.axi_aw_id_o    = {{(ID_W-1){1'b0}}, 1'b1};
        bus.axi_aw_len_o   = 8'd0;
        bus.axi_aw_size_o  = r_size;
        bus.axi_aw_burst_o = 2'b01;
        bus.axi_w_valid_o  = (r_state == S_WR) && !r_w_done;
        bus.axi_w_data_o   = r_wdata;
        bus.axi_w_strb_o   = r_wstrb;
        bus.axi_w_last_o   = 1'b1;
        bus.axi_b_ready_o  = (r_state == S_B);
    end
endmodule
